evk_led_sequencer: RTL and testbench
====================================

// Module: evk_led_sequencer
// PURPOSE
//  Generates the three PWM enables (RGB0PWM..RGB2PWM) for the EVK RGB LED driver from a single config port.
//  Each channel has an 8-bit duty and an optional blink.
//  Duty updates are double-buffered and committed only at PWM period boundaries, so the LEDs never glitch.
//  Sits between debug/control logic and the evkLeds driver wrapper; its outputs feed evkLeds debug1..3.
// PARAMETERS
//  PRESCALE       4    clk cycles per PWM count step (>=1); PWM period = 256*PRESCALE clks
//  BLINK_PERIODS  64   PWM periods per blink half-phase (>=1)
// PORTS
//  clk           in   1  system clock, all logic rising-edge
//  rst_n         in   1  synchronous active-low reset
//  cfg_valid     in   1  config request valid
//  cfg_ready     out  1  config request may be accepted this cycle
//  cfg_chan      in   2  target channel 0..2; 3 = broadcast to all three
//  cfg_duty      in   8  on-count per 256-step period
//  cfg_blink     in   1  1 = gate channel with blink phase
//  pwm_out       out  3  registered PWM enables, bit i -> RGBiPWM
//  period_start  out  1  one-clk pulse on the cycle pwm_cnt steps 255->0
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge) clears all state and outputs:
//   - pwm_out=0, period_start=0, cfg_ready=1
//   - duty_shadow, duty_active and blink enables all 0
//   - pre_cnt=0, pwm_cnt=0, blink_cnt=0, blink_phase=1, FSM=IDLE
//  Reset mid-period or mid-PENDING discards any uncommitted config.
//  Prescaler:
//   - pre_cnt counts 0..PRESCALE-1; tick=1 when pre_cnt==PRESCALE-1, then pre_cnt wraps to 0.
//   - On tick, pwm_cnt (8b) increments and wraps 255->0.
//  Boundary: bnd = tick && pwm_cnt==255. Registered period_start=1 on the clk after bnd.
//  Blink:
//   - On bnd, blink_cnt increments.
//   - When blink_cnt==BLINK_PERIODS-1 and bnd: blink_cnt->0 and blink_phase toggles.
//  Output: pwm_out[i] <= (pwm_cnt < duty_active[i]) && (!blink_active[i] || blink_phase).
//   - One-clk latency from the counter to the pin.
//   - duty 0 = always off; duty 255 = on 255 of 256 steps.
//  Config FSM:
//   - IDLE: cfg_ready=1. cfg_valid&&cfg_ready accepts the request:
//     - writes duty_shadow/blink_shadow for cfg_chan (all three if cfg_chan==3)
//     - next state PENDING, cfg_ready->0
//   - PENDING: cfg_ready=0; cfg_valid ignored.
//     - On bnd: active<=shadow for all channels, FSM->IDLE, cfg_ready->1 next clk.
//  Commit timing:
//   - New values take effect from pwm_cnt==0 of the following period.
//   - An accept on the same clk as bnd does NOT commit at that bnd; it waits for the next one.
//  Blink gating: blink_phase is shared by all channels. Clearing blink on a channel only affects that channel.
//  Width: all compares are unsigned 8-bit; counter widths are $clog2 of their parameters, minimum 1 bit.
//  Requester holds cfg_* stable while cfg_valid=1 && cfg_ready=0 (standard valid/ready).
// TESTING
//  (All with PRESCALE=1, BLINK_PERIODS=2 unless noted.)
//  1. Reset:
//     - assert rst_n=0 for 3 clks -> pwm_out=0, cfg_ready=1, period_start=0
//     - release -> pwm_out stays 0 through 2 full periods
//  2. Duty commit:
//     - write chan0 duty=64 blink=0 -> cfg_ready low until the next bnd
//     - following period: pwm_out[0] high exactly 64 clks, starting 1 clk after pwm_cnt=0
//  3. Broadcast + extremes:
//     - chan=3 duty=255 -> each bit high 255/256 clks per period
//     - chan=3 duty=0 -> all bits low
//  4. Blink:
//     - chan1 duty=128 blink=1 -> pwm_out[1] active 2 periods, dark 2 periods, repeating
//     - chan2 duty=128 blink=0 -> pwm_out[2] unaffected
//  5. Simultaneous accept at bnd:
//     - cfg_valid on the bnd clk -> commit delayed one full period (256 clks)
//     - cfg_valid held during PENDING -> not re-accepted
//  6. Reset mid-PENDING:
//     - accept duty=200, assert rst_n=0 before bnd -> duty stays 0, cfg_ready=1 next clk after release
//  7. PRESCALE=4:
//     - duty=10 -> pwm_out high 40 clks per 1024-clk period
//     - period_start pulses every 1024 clks

Source files
------------

// File: rtl/evk_led_sequencer.sv
// Three-channel PWM sequencer for the EVK RGB LED driver.
// Duty/blink updates land in a shadow bank and are committed to the active
// bank only at a PWM period boundary, so a period is never cut short.
module evk_led_sequencer #(
   parameter int unsigned PRESCALE      = 4,
   parameter int unsigned BLINK_PERIODS = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cfg_valid,
   output logic       cfg_ready,
   input  logic [1:0] cfg_chan,
   input  logic [7:0] cfg_duty,
   input  logic       cfg_blink,
   output logic [2:0] pwm_out,
   output logic       period_start
);

   localparam int unsigned NCH    = 3;
   localparam int unsigned DUTY_W = 8;
   localparam int unsigned PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int unsigned BLK_W  = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PENDING = 1'b1
   } state_e;

   state_e                        state_q, state_d;
   logic                          cfg_ready_q, cfg_ready_d;
   logic [PRE_W-1:0]              pre_cnt_q, pre_cnt_d;
   logic [DUTY_W-1:0]             pwm_cnt_q, pwm_cnt_d;
   logic [BLK_W-1:0]              blink_cnt_q, blink_cnt_d;
   logic                          blink_phase_q, blink_phase_d;
   logic [NCH-1:0][DUTY_W-1:0]    duty_shadow_q, duty_shadow_d;
   logic [NCH-1:0][DUTY_W-1:0]    duty_active_q, duty_active_d;
   logic [NCH-1:0]                blink_shadow_q, blink_shadow_d;
   logic [NCH-1:0]                blink_active_q, blink_active_d;
   logic [NCH-1:0]                pwm_out_q, pwm_out_d;
   logic                          period_start_q, period_start_d;
   logic                          tick;
   logic                          bnd;

   assign tick = (pre_cnt_q == PRE_W'(PRESCALE - 1));
   assign bnd  = tick && (pwm_cnt_q == DUTY_W'(255));

   // Prescaler, PWM counter, blink phase and the registered pin compare.
   always_comb begin
      pre_cnt_d      = tick ? '0 : pre_cnt_q + PRE_W'(1);
      pwm_cnt_d      = tick ? pwm_cnt_q + DUTY_W'(1) : pwm_cnt_q;
      blink_cnt_d    = blink_cnt_q;
      blink_phase_d  = blink_phase_q;
      period_start_d = bnd;
      if (bnd) begin
         if (blink_cnt_q == BLK_W'(BLINK_PERIODS - 1)) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + BLK_W'(1);
         end
      end
      for (int unsigned i = 0; i < NCH; i++) begin
         pwm_out_d[i] = (pwm_cnt_q < duty_active_q[i]) &&
                        (!blink_active_q[i] || blink_phase_q);
      end
   end

   // Config FSM: accept into the shadow bank in IDLE, commit at the next boundary in PENDING.
   always_comb begin
      state_d        = state_q;
      duty_shadow_d  = duty_shadow_q;
      blink_shadow_d = blink_shadow_q;
      duty_active_d  = duty_active_q;
      blink_active_d = blink_active_q;
      unique case (state_q)
         ST_IDLE: begin
            if (cfg_valid) begin
               for (int unsigned i = 0; i < NCH; i++) begin
                  if (cfg_chan == 2'(i) || cfg_chan == 2'd3) begin
                     duty_shadow_d[i]  = cfg_duty;
                     blink_shadow_d[i] = cfg_blink;
                  end
               end
               state_d = ST_PENDING;
            end
         end
         ST_PENDING: begin
            if (bnd) begin
               duty_active_d  = duty_shadow_q;
               blink_active_d = blink_shadow_q;
               state_d        = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      cfg_ready_d = (state_d == ST_IDLE);
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cfg_ready_q    <= 1'b1;
         pre_cnt_q      <= '0;
         pwm_cnt_q      <= '0;
         blink_cnt_q    <= '0;
         blink_phase_q  <= 1'b1;
         duty_shadow_q  <= '0;
         duty_active_q  <= '0;
         blink_shadow_q <= '0;
         blink_active_q <= '0;
         pwm_out_q      <= '0;
         period_start_q <= 1'b0;
      end else begin
         cfg_ready_q    <= cfg_ready_d;
         pre_cnt_q      <= pre_cnt_d;
         pwm_cnt_q      <= pwm_cnt_d;
         blink_cnt_q    <= blink_cnt_d;
         blink_phase_q  <= blink_phase_d;
         duty_shadow_q  <= duty_shadow_d;
         duty_active_q  <= duty_active_d;
         blink_shadow_q <= blink_shadow_d;
         blink_active_q <= blink_active_d;
         pwm_out_q      <= pwm_out_d;
         period_start_q <= period_start_d;
      end
   end

   assign cfg_ready    = cfg_ready_q;
   assign pwm_out      = pwm_out_q;
   assign period_start = period_start_q;

endmodule

// File: tb/tb_evk_led_sequencer.sv
// Directed bench for evk_led_sequencer: instance A uses PRESCALE=1,
// BLINK_PERIODS=2; instance B uses PRESCALE=4 for the prescaler scenario.
module tb_evk_led_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       a_valid, a_ready, a_blink, a_ps;
   logic [1:0] a_chan;
   logic [7:0] a_duty;
   logic [2:0] a_pwm;
   logic       b_valid, b_ready, b_blink, b_ps;
   logic [1:0] b_chan;
   logic [7:0] b_duty;
   logic [2:0] b_pwm;

   int n_checks = 0;
   int n_pass   = 0;
   int m_ones[3];
   int m_first[3];
   int m_ps;
   int m_rdy;

   always #5 clk = ~clk;

   evk_led_sequencer #(.PRESCALE(1), .BLINK_PERIODS(2)) u_a (
      .clk(clk), .rst_n(rst_n),
      .cfg_valid(a_valid), .cfg_ready(a_ready), .cfg_chan(a_chan),
      .cfg_duty(a_duty), .cfg_blink(a_blink),
      .pwm_out(a_pwm), .period_start(a_ps)
   );

   evk_led_sequencer #(.PRESCALE(4), .BLINK_PERIODS(2)) u_b (
      .clk(clk), .rst_n(rst_n),
      .cfg_valid(b_valid), .cfg_ready(b_ready), .cfg_chan(b_chan),
      .cfg_duty(b_duty), .cfg_blink(b_blink),
      .pwm_out(b_pwm), .period_start(b_ps)
   );

   // Advance n clocks, landing 1 time unit after the rising edge.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Wait (bounded) for the period_start cycle of instance A.
   task automatic sync_a(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         if (a_ps) begin
            ok = 1'b1;
            break;
         end
         step(1);
      end
   endtask

   // Sample one 256-clk period of instance A starting on its period_start cycle.
   task automatic measure_a();
      for (int c = 0; c < 3; c++) begin
         m_ones[c]  = 0;
         m_first[c] = -1;
      end
      m_ps  = 0;
      m_rdy = 0;
      for (int k = 0; k < 256; k++) begin
         for (int c = 0; c < 3; c++) begin
            if (a_pwm[c]) begin
               if (m_first[c] < 0) m_first[c] = k;
               m_ones[c]++;
            end
         end
         if (a_ps) m_ps++;
         if (a_ready) m_rdy++;
         step(1);
      end
   endtask

   // One-clock config request on A (caller guarantees the FSM is IDLE).
   task automatic write_a(input logic [1:0] chan, input logic [7:0] duty, input logic blink);
      a_chan  = chan;
      a_duty  = duty;
      a_blink = blink;
      a_valid = 1'b1;
      step(1);
      a_valid = 1'b0;
   endtask

   task automatic test_reset();
      int n;
      int hi;
      rst_n = 1'b0;
      step(3);
      n_checks++; if (a_pwm !== 3'b000) $display("FAIL rst_pwm: got %b want 000", a_pwm); else n_pass++;
      n_checks++; if (a_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", a_ready); else n_pass++;
      n_checks++; if (a_ps !== 1'b0) $display("FAIL rst_ps: got %b want 0", a_ps); else n_pass++;
      n_checks++; if (b_ready !== 1'b1 || b_pwm !== 3'b000) $display("FAIL rst_b: got ready=%b pwm=%b want 1/000", b_ready, b_pwm); else n_pass++;
      rst_n = 1'b1;
      n  = 0;
      hi = 0;
      while (!a_ps && n < 600) begin
         if (a_pwm !== 3'b000) hi++;
         step(1);
         n++;
      end
      n_checks++; if (n !== 256) $display("FAIL rst_first_period: got %0d clks want 256", n); else n_pass++;
      measure_a();
      hi += m_ones[0] + m_ones[1] + m_ones[2];
      n_checks++; if (hi !== 0) $display("FAIL rst_pwm_idle: got %0d high samples want 0", hi); else n_pass++;
   endtask

   task automatic test_duty_commit();
      int low;
      int n;
      bit ok;
      write_a(2'd0, 8'd64, 1'b0);
      n_checks++; if (a_ready !== 1'b0) $display("FAIL commit_ready_drop: got %b want 0", a_ready); else n_pass++;
      low = 0;
      n   = 0;
      while (!a_ps && n < 600) begin
         if (!a_ready) low++;
         step(1);
         n++;
      end
      n_checks++; if (low !== 255) $display("FAIL commit_ready_low: got %0d clks want 255", low); else n_pass++;
      n_checks++; if (a_ready !== 1'b1) $display("FAIL commit_ready_back: got %b want 1", a_ready); else n_pass++;
      sync_a(ok);
      measure_a();
      n_checks++; if (m_ones[0] !== 64) $display("FAIL duty64_ones: got %0d want 64", m_ones[0]); else n_pass++;
      n_checks++; if (m_first[0] !== 1) $display("FAIL duty64_first: got %0d want 1", m_first[0]); else n_pass++;
      n_checks++; if (m_ones[1] !== 0 || m_ones[2] !== 0) $display("FAIL duty64_others: got %0d/%0d want 0/0", m_ones[1], m_ones[2]); else n_pass++;
   endtask

   task automatic test_broadcast();
      bit ok;
      write_a(2'd3, 8'd255, 1'b0);
      sync_a(ok);
      n_checks++; if (!ok) $display("FAIL bcast_sync: got timeout want period_start"); else n_pass++;
      measure_a();
      for (int c = 0; c < 3; c++) begin
         n_checks++; if (m_ones[c] !== 255) $display("FAIL bcast255_ch%0d: got %0d want 255", c, m_ones[c]); else n_pass++;
      end
      write_a(2'd3, 8'd0, 1'b0);
      sync_a(ok);
      measure_a();
      n_checks++; if (m_ones[0] + m_ones[1] + m_ones[2] !== 0) $display("FAIL bcast0: got %0d highs want 0", m_ones[0] + m_ones[1] + m_ones[2]); else n_pass++;
   endtask

   task automatic test_blink();
      bit ok;
      int p1[8];
      int p2_ok;
      int p1_valid;
      int p1_on;
      int alt;
      int ch0;
      write_a(2'd1, 8'd128, 1'b1);
      sync_a(ok);
      write_a(2'd2, 8'd128, 1'b0);
      sync_a(ok);
      n_checks++; if (!ok) $display("FAIL blink_sync: got timeout want period_start"); else n_pass++;
      p2_ok = 0; p1_valid = 0; p1_on = 0; ch0 = 0;
      for (int k = 0; k < 8; k++) begin
         measure_a();
         p1[k] = m_ones[1];
         if (m_ones[2] == 128) p2_ok++;
         if (m_ones[1] == 0 || m_ones[1] == 128) p1_valid++;
         if (m_ones[1] == 128) p1_on++;
         ch0 += m_ones[0];
      end
      alt = 0;
      for (int k = 0; k < 6; k++) if (p1[k] != p1[k+2]) alt++;
      n_checks++; if (p2_ok !== 8) $display("FAIL blink_ch2_steady: got %0d periods want 8", p2_ok); else n_pass++;
      n_checks++; if (p1_valid !== 8) $display("FAIL blink_ch1_levels: got %0d periods want 8", p1_valid); else n_pass++;
      n_checks++; if (p1_on !== 4) $display("FAIL blink_ch1_on: got %0d periods want 4", p1_on); else n_pass++;
      n_checks++; if (alt !== 6) $display("FAIL blink_ch1_2on2off: got %0d toggles want 6", alt); else n_pass++;
      n_checks++; if (ch0 !== 0) $display("FAIL blink_ch0: got %0d want 0", ch0); else n_pass++;
   endtask

   task automatic test_back_to_back();
      step(255);
      a_chan  = 2'd0;
      a_duty  = 8'd50;
      a_blink = 1'b0;
      a_valid = 1'b1;
      step(1);
      n_checks++; if (a_ps !== 1'b1) $display("FAIL bnd_align: got %b want 1", a_ps); else n_pass++;
      n_checks++; if (a_ready !== 1'b0) $display("FAIL bnd_pending: got %b want 0", a_ready); else n_pass++;
      measure_a();
      n_checks++; if (m_ones[0] !== 0) $display("FAIL bnd_not_early: got %0d want 0", m_ones[0]); else n_pass++;
      n_checks++; if (m_rdy !== 0) $display("FAIL bnd_hold_ignored: got %0d ready clks want 0", m_rdy); else n_pass++;
      n_checks++; if (a_ready !== 1'b1) $display("FAIL bnd_commit_ready: got %b want 1", a_ready); else n_pass++;
      a_valid = 1'b0;
      measure_a();
      n_checks++; if (m_ones[0] !== 50) $display("FAIL bnd_duty50: got %0d want 50", m_ones[0]); else n_pass++;
      n_checks++; if (m_rdy !== 256) $display("FAIL bnd_no_reaccept: got %0d ready clks want 256", m_rdy); else n_pass++;
   endtask

   task automatic test_reset_pending();
      bit ok;
      write_a(2'd0, 8'd200, 1'b0);
      n_checks++; if (a_ready !== 1'b0) $display("FAIL rstp_pending: got %b want 0", a_ready); else n_pass++;
      step(20);
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(1);
      n_checks++; if (a_ready !== 1'b1) $display("FAIL rstp_ready: got %b want 1", a_ready); else n_pass++;
      sync_a(ok);
      measure_a();
      n_checks++; if (m_ones[0] !== 0) $display("FAIL rstp_ch0: got %0d want 0", m_ones[0]); else n_pass++;
      n_checks++; if (m_ones[1] + m_ones[2] !== 0) $display("FAIL rstp_cleared: got %0d want 0", m_ones[1] + m_ones[2]); else n_pass++;
   endtask

   task automatic test_prescale4();
      int n;
      int ones;
      int first;
      int other;
      int ps;
      n = 0;
      while (!b_ps && n < 3000) begin step(1); n++; end
      b_chan  = 2'd0;
      b_duty  = 8'd10;
      b_blink = 1'b0;
      b_valid = 1'b1;
      step(1);
      b_valid = 1'b0;
      n = 0;
      while (!b_ps && n < 3000) begin step(1); n++; end
      n_checks++; if (b_ps !== 1'b1) $display("FAIL ps4_sync: got %b want 1", b_ps); else n_pass++;
      ones = 0; first = -1; other = 0; ps = 0;
      for (int k = 0; k < 1024; k++) begin
         if (b_pwm[0]) begin
            if (first < 0) first = k;
            ones++;
         end
         if (b_pwm[2:1] != 2'b00) other++;
         if (b_ps) ps++;
         step(1);
      end
      n_checks++; if (ones !== 40) $display("FAIL ps4_ones: got %0d want 40", ones); else n_pass++;
      n_checks++; if (first !== 1) $display("FAIL ps4_first: got %0d want 1", first); else n_pass++;
      n_checks++; if (other !== 0) $display("FAIL ps4_others: got %0d want 0", other); else n_pass++;
      n_checks++; if (ps !== 1) $display("FAIL ps4_pulses: got %0d want 1", ps); else n_pass++;
      n_checks++; if (b_ps !== 1'b1) $display("FAIL ps4_period1024: got %b want 1", b_ps); else n_pass++;
   endtask

   initial begin
      rst_n   = 1'b0;
      a_valid = 1'b0; a_chan = 2'd0; a_duty = 8'd0; a_blink = 1'b0;
      b_valid = 1'b0; b_chan = 2'd0; b_duty = 8'd0; b_blink = 1'b0;
      step(1);
      test_reset();
      test_duty_commit();
      test_broadcast();
      test_blink();
      test_back_to_back();
      test_reset_pending();
      test_prescale4();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
